// File: rtl/inv_key_sched_128_if.sv
// Handshake bundle for the AES-128 inverse key schedule: key load channel
// in, round-key stream out.
interface inv_key_sched_128_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_idx, rk_valid, rk_last
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_idx, rk_valid, rk_last
  );
endinterface

// File: rtl/inv_key_sched_128.sv
// Iterative AES-128 inverse key schedule. Loads round key NR and emits round
// keys NR down to 0, one per handshake.
// Build option: INV_KS_PIPE_EN registers the SubWord output so each backward
// step takes two cycles (one idle cycle on rk_valid between keys).
module inv_key_sched_128 #(
  parameter int unsigned NR = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  inv_key_sched_128_if.slave ks
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_STEP = 2'd2
  } state_e;

  localparam logic [3:0] NR_IDX = 4'(NR);

  // Forward AES sbox, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Byte b sits at bits [8*(255-b)+7 -: 8] = [{~b,3'b111} -: 8].
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Undo one expansion step given the precomputed SubWord(RotWord(w3^w2)).
  function automatic logic [127:0] prev_key(input logic [127:0] k,
                                            input logic [31:0]  sw,
                                            input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    return {w0 ^ sw ^ {rc, 24'h000000}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  endfunction

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         ready_q, ready_d;

  logic [31:0]  p3_s;
  logic [31:0]  sw_s;
  logic [31:0]  step_sw_s;
  logic [127:0] prev_s;

  assign p3_s   = key_q[31:0] ^ key_q[63:32];
  assign sw_s   = sub_word({p3_s[23:0], p3_s[31:24]});
  assign prev_s = prev_key(key_q, step_sw_s, rcon(idx_q));

`ifdef INV_KS_PIPE_EN
  logic [31:0] sw_q;

  // SubWord result register; key_q is stable during the transfer cycle,
  // so sw_q is valid for the following STEP cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_q <= 32'h00000000;
    end else begin
      sw_q <= sw_s;
    end
  end

  assign step_sw_s = sw_q;
`else
  assign step_sw_s = sw_s;
`endif

  // Next-state, datapath update and registered output values.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (ks.key_valid) begin
          key_d   = ks.key_in;
          idx_d   = NR_IDX;
          state_d = S_EMIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (ks.rk_ready) begin
          if (idx_q != 4'd0) begin
`ifdef INV_KS_PIPE_EN
            state_d = S_STEP;
`else
            key_d   = prev_s;
            idx_d   = idx_q - 4'd1;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_STEP: begin
        key_d   = prev_s;
        idx_d   = idx_q - 4'd1;
        state_d = S_EMIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    valid_d = (state_d == S_EMIT);
    last_d  = valid_d && (idx_d == 4'd0);
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= 128'd0;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  assign ks.rk_out    = key_q;
  assign ks.rk_idx    = idx_q;
  assign ks.rk_valid  = valid_q;
  assign ks.rk_last   = last_q;
  assign ks.key_ready = ready_q;

endmodule

// File: tb/tb_inv_key_sched_128.sv
// Self-checking bench for inv_key_sched_128: FIPS-197 A.1 round-key table,
// scoreboard of expected keys, back-pressure, ignored loads, mid-sequence
// reset, back-to-back loads and an NR=1 instance.
module tb_inv_key_sched_128;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         last;
  } vec_t;

`ifdef INV_KS_PIPE_EN
  localparam logic GAP_VALID = 1'b0;
`else
  localparam logic GAP_VALID = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_key_sched_128_if bus ();
  inv_key_sched_128_if bus1 ();

  inv_key_sched_128 #(.NR(10)) u_dut  (.clk(clk), .rst_n(rst_n), .ks(bus));
  inv_key_sched_128 #(.NR(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .ks(bus1));

  vec_t vec [11];
  vec_t sb [$];
  vec_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  logic [127:0] held_key;
  logic [3:0]   held_idx;
  bit   hold_pend = 1'b0;
  bit   gap_pend  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event, expected normal progress", name);
  endtask

  // Scoreboard monitor for the NR=10 instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
      gap_pend  = 1'b0;
    end else begin
      if (gap_pend) chk("step_gap_valid", 128'(bus.rk_valid), 128'(GAP_VALID));
      if (hold_pend) begin
        chk("hold_valid", 128'(bus.rk_valid), 128'(1'b1));
        chk("hold_key", bus.rk_out, held_key);
        chk("hold_idx", 128'(bus.rk_idx), 128'(held_idx));
      end
      if (bus.rk_valid) chk("busy_key_ready", 128'(bus.key_ready), 128'(1'b0));
      gap_pend = 1'b0;
      if (bus.rk_valid && bus.rk_ready) begin
        xfers++;
        if (sb.size() == 0) begin
          fail_now("unexpected_transfer");
        end else begin
          mon_e = sb.pop_front();
          chk("rk_out", bus.rk_out, mon_e.key);
          chk("rk_idx", 128'(bus.rk_idx), 128'(mon_e.idx));
          chk("rk_last", 128'(bus.rk_last), 128'(mon_e.last));
        end
        gap_pend = (bus.rk_idx != 4'd0);
      end
      hold_pend = bus.rk_valid && !bus.rk_ready;
      held_key  = bus.rk_out;
      held_idx  = bus.rk_idx;
    end
  end

  // Present a key until accepted, then queue the expected 11-key sequence.
  task automatic do_load(input logic [127:0] k, output int waited);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    for (waited = 0; waited < 50; waited++) begin
      @(negedge clk);
      if (bus.key_ready === 1'b1) break;
    end
    if (waited == 50) begin
      fail_now("load_timeout");
    end else begin
      for (int r = 10; r >= 0; r--) sb.push_back(vec[r]);
    end
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  // Drive rk_ready until the scoreboard drains or max_x transfers occurred.
  task automatic run_seq(input bit bp, input bit intrude, input int max_x);
    int start;
    bit done;
    start = xfers;
    done  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (sb.size() == 0 || (xfers - start) >= max_x) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      bus.rk_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.key_valid = intrude && (c >= 2) && (c < 8);
      if (intrude) bus.key_in = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    end
    bus.key_valid = 1'b0;
    if (!done) fail_now("sequence_timeout");
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x0;
    int w;
    bit found;
    vec[0].key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vec[1].key  = 128'ha0fafe1788542cb123a339392a6c7605;
    vec[2].key  = 128'hf2c295f27a96b9435935807a7359f67f;
    vec[3].key  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    vec[4].key  = 128'hef44a541a8525b7fb671253bdb0bad00;
    vec[5].key  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    vec[6].key  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    vec[7].key  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    vec[8].key  = 128'head27321b58dbad2312bf5607f8d292f;
    vec[9].key  = 128'hac7766f319fadc2128d12941575c006e;
    vec[10].key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int r = 0; r < 11; r++) begin
      vec[r].idx  = 4'(r);
      vec[r].last = (r == 0);
    end

    rst_n = 1'b0;
    bus.key_in = 128'd0;   bus.key_valid = 1'b0;  bus.rk_ready = 1'b0;
    bus1.key_in = 128'd0;  bus1.key_valid = 1'b0; bus1.rk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 128'(bus.rk_valid), 128'(1'b0));
    chk("rst_out", bus.rk_out, 128'd0);
    chk("rst_idx", 128'(bus.rk_idx), 128'd0);
    chk("rst_last", 128'(bus.rk_last), 128'(1'b0));
    chk("rst_key_ready", 128'(bus.key_ready), 128'(1'b1));
    chk("rst_key_ready_nr1", 128'(bus1.key_ready), 128'(1'b1));
    @(posedge clk);
    #1;

    // FIPS-197 A.1 full speed.
    x0 = xfers;
    do_load(vec[10].key, w);
    run_seq(1'b0, 1'b0, 99);
    chk("t1_transfers", 128'(xfers - x0), 128'd11);

    // Random back-pressure.
    x0 = xfers;
    do_load(vec[10].key, w);
    run_seq(1'b1, 1'b0, 99);
    chk("t2_transfers", 128'(xfers - x0), 128'd11);

    // Load attempts during EMIT are ignored.
    x0 = xfers;
    do_load(vec[10].key, w);
    run_seq(1'b1, 1'b1, 99);
    chk("t3_transfers", 128'(xfers - x0), 128'd11);

    // Back-to-back: reload the cycle key_ready returns.
    x0 = xfers;
    do_load(vec[10].key, w);
    run_seq(1'b0, 1'b0, 99);
    do_load(vec[10].key, w);
    chk("t5_b2b_wait", 128'(w), 128'd0);
    run_seq(1'b0, 1'b0, 99);
    chk("t5_transfers", 128'(xfers - x0), 128'd22);

    // Reset after the idx7 transfer, then a fresh sequence.
    x0 = xfers;
    do_load(vec[10].key, w);
    run_seq(1'b0, 1'b0, 4);
    chk("t4_pre_reset_transfers", 128'(xfers - x0), 128'd4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t4_valid", 128'(bus.rk_valid), 128'(1'b0));
    chk("t4_out", bus.rk_out, 128'd0);
    chk("t4_key_ready", 128'(bus.key_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    x0 = xfers;
    do_load(vec[10].key, w);
    run_seq(1'b1, 1'b0, 99);
    chk("t4_transfers", 128'(xfers - x0), 128'd11);

    // NR=1 instance, hand-written sequence.
    bus1.key_in    = vec[1].key;
    bus1.key_valid = 1'b1;
    bus1.rk_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus1.key_valid = 1'b0;
    for (int r = 1; r >= 0; r--) begin
      found = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus1.rk_valid) begin
          found = 1'b1;
          break;
        end
      end
      chk("nr1_valid", 128'(found), 128'(1'b1));
      chk("nr1_key", bus1.rk_out, vec[r].key);
      chk("nr1_idx", 128'(bus1.rk_idx), 128'(vec[r].idx));
      chk("nr1_last", 128'(bus1.rk_last), 128'(vec[r].last));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("nr1_done_valid", 128'(bus1.rk_valid), 128'(1'b0));
    chk("nr1_done_key_ready", 128'(bus1.key_ready), 128'(1'b1));

    repeat (3) @(posedge clk);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
